pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register for the PCPU pipeline. It is the successor to the fixed-field, always-advancing inter-stage registers. It carries one opaque payload bus with a valid/ready handshake and a 2-entry skid buffer, so a stage can stall without a combinational ready path back upstream. It also supports synchronous flush, an optional zero-on-bubble payload policy, and a saturating stall counter. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
Parameters:
- PAYLOAD_W, 175: payload width. Default packs PC(32), rs1(5), rs2(5), rd(5), ctrl(32), RD1(32), RD2(32), imm(32).
- ZERO_BUBBLE, 1: 1 means payload registers are cleared to 0 on reset or flush. 0 means only the valid bits are cleared and payload holds its value.
- CNT_W, 16: width of the stall counter.

Ports:
- Clk, input, 1: clock. One clock, rising edge.
- Rst, input, 1: reset. Synchronous, active-high.
- flush, input, 1: discard all held entries at the next edge.
- in_valid, input, 1: upstream offers in_data.
- in_ready, output, 1: stage accepts. Driven from a register.
- in_data, input, PAYLOAD_W: upstream payload.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, PAYLOAD_W: payload presented downstream.
- skid_full, output, 1: both entries occupied.
- stall_cnt, output, CNT_W: saturating count of stalled cycles.
- stall_clr, input, 1: clears stall_cnt at the next edge.

## Operation
- Storage: main entry (m_valid, m_data) drives out_*. Skid entry (s_valid, s_data) holds overflow.
- States: EMPTY (!m_valid), BUSY (m_valid & !s_valid), FULL (m_valid & s_valid).
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- in_ready = !s_valid. out_valid = m_valid. out_data = m_data. skid_full = s_valid.
- EMPTY, in_xfer: main <= in_data, go to BUSY.
- BUSY, in_xfer & out_xfer: main <= in_data, stay BUSY.
- BUSY, in_xfer & !out_xfer: skid <= in_data, go to FULL.
- BUSY, !in_xfer & out_xfer: go to EMPTY.
- BUSY, no transfer: hold.
- FULL, out_xfer: main <= skid, go to BUSY. No in_xfer is possible in FULL because in_ready is 0.
- FULL, otherwise: hold.
- Ordering: entries leave in arrival order. No payload is dropped or duplicated unless flush is asserted.
- Flush, priority Rst > flush > normal:
  - Next state is EMPTY.
  - An input offered in the flush cycle is discarded even if in_ready was 1.
  - An out_xfer in the flush cycle still counts as delivered downstream.
- ZERO_BUBBLE=1: reset and flush clear m_data and s_data to 0, so a flushed stage emits an all-zero control word (NOP).
- Reset values: m_valid=0, s_valid=0, in_ready=1, out_valid=0, skid_full=0, stall_cnt=0. out_data=0 when ZERO_BUBBLE=1; otherwise undefined until the first load.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stall_clr has priority over increment and sets stall_cnt to 0.
  - Flush does not clear stall_cnt; Rst does.

## Timing
- Latency: in_xfer at edge N gives out_valid=1 with that payload after edge N (visible in cycle N+1).
- Throughput: 1 transfer per cycle in steady state with out_ready held high.
- in_ready depends only on state. There is no combinational path from out_ready or in_valid to in_ready.
- out_ready low for k cycles while in_valid stays high: exactly one extra beat is absorbed, then in_ready drops in the following cycle.
- After FULL drains by one entry, in_ready returns to 1 one cycle after the out_xfer.
- Flush or Rst asserted mid-operation: out_valid=0 and in_ready=1 in the cycle after the edge.

## Structure
- Shared package pcpu_pipe_pkg contains:
  - Field width constants: PC_W=32, REG_W=5, CTRL_W=32, XLEN=32.
  - Default PAYLOAD_W derived from those constants.
  - Field offset localparams used by stages to pack and unpack the payload.
  - State enum EMPTY/BUSY/FULL (2-bit).
- Single module; no sub-module needed. The counter is small enough to stay inline.

## Test plan
- Streaming: out_ready=1, in_valid=1, data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later, no gaps, skid_full never 1.
- Backpressure: out_ready=0 for 3 cycles while feeding 0xA, 0xB, 0xC -> in_ready falls after 0xB is accepted, 0xC is held upstream. Release -> outputs in order 0xA, 0xB, 0xC; stall_cnt=3.
- Flush in FULL with in_valid=1 (data 0xD) -> next cycle out_valid=0, in_ready=1, out_data=0 (ZERO_BUBBLE=1), 0xD never appears.
- Flush with ZERO_BUBBLE=0 -> out_valid=0 and out_data holds its last value.
- Stall counter with CNT_W=4, 20 stalled cycles -> stall_cnt=15 (saturated). Assert stall_clr with a stall in the same cycle -> stall_cnt=0.
- Rst asserted while FULL and stall_cnt=5 -> all outputs return to reset values at the next edge. Rst with no clock edge changes nothing (synchronous reset).

Source files
------------

// File: rtl/pcpu_pipe_pkg.sv
// Shared definitions for the PCPU inter-stage registers: field widths,
// payload packing offsets and the stage occupancy encoding.
package pcpu_pipe_pkg;

  localparam int PC_W   = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 32;
  localparam int XLEN   = 32;

  // Default payload: PC, rs1, rs2, rd, ctrl, RD1, RD2, imm (imm at bit 0)
  localparam int PAYLOAD_W_DEF = PC_W + 3 * REG_W + CTRL_W + 3 * XLEN;

  localparam int IMM_LSB  = 0;
  localparam int RD2_LSB  = IMM_LSB + XLEN;
  localparam int RD1_LSB  = RD2_LSB + XLEN;
  localparam int CTRL_LSB = RD1_LSB + XLEN;
  localparam int RD_LSB   = CTRL_LSB + CTRL_W;
  localparam int RS2_LSB  = RD_LSB + REG_W;
  localparam int RS1_LSB  = RS2_LSB + REG_W;
  localparam int PC_LSB   = RS1_LSB + REG_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer: 1-cycle latency, full throughput.
// Backpressure: in_ready is decoded from registered state only, so out_ready never reaches it combinationally.
module pipe_stage_reg
  import pcpu_pipe_pkg::*;
#(
  parameter int PAYLOAD_W   = PAYLOAD_W_DEF,
  parameter bit ZERO_BUBBLE = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic                 skid_full,
  output logic [CNT_W-1:0]     stall_cnt,
  input  logic                 stall_clr
);

  stage_state_e         state;
  stage_state_e         state_nxt;
  logic [PAYLOAD_W-1:0] m_data;
  logic [PAYLOAD_W-1:0] s_data;
  logic                 in_xfer;
  logic                 out_xfer;
  logic                 load_m_in;
  logic                 load_m_skid;
  logic                 load_s;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign out_data = m_data;

  always_ff @(posedge Clk) begin
    if (Rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            load_m_in = 1'b1;
            state_nxt = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            load_m_in = 1'b1;
          end else if (in_xfer) begin
            load_s    = 1'b1;
            state_nxt = FULL;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists
          if (out_xfer) begin
            load_m_skid = 1'b1;
            state_nxt   = BUSY;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    skid_full = (state == FULL);
  end

  always_ff @(posedge Clk) begin
    if ((Rst || flush) && ZERO_BUBBLE) begin
      m_data <= '0;
      s_data <= '0;
    end else if (!Rst) begin
      if (load_m_in)        m_data <= in_data;
      else if (load_m_skid) m_data <= s_data;
      if (load_s)           s_data <= in_data;
    end
  end

  // Counts cycles where a valid beat is refused; flush deliberately leaves it alone
  always_ff @(posedge Clk) begin
    if (Rst || stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
